serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial subtractor; the inverse operation of the 4-bit ripple-carry adder block.
- Computes diff = a - b - bin over WIDTH clock cycles, LSB first, through one shared 1-bit full-subtractor cell.
- Uses a start/busy/done handshake so a driver or controller can issue back-to-back operations.
- Sits beside the adder in the arithmetic library; its results are cross-checked against the adder (a + ~b + ~bin).

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; operands are sampled on the same edge.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when diff/borrow become valid.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- borrow  output  1  borrow-out; 1 when a < b + bin, unsigned.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, diff=0, borrow=0, counter=0, internal shift registers cleared.
- Reset has priority over all other inputs and aborts any operation mid-flight. No done is produced for the aborted operation.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at edge k:
  - Latch a, b and bin into shift registers and the borrow flop.
  - Go to BUSY, counter=0, busy=1 from edge k onward.
- BUSY, each edge:
  - Bit i = counter: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d_i into the result register MSB-side, so after WIDTH shifts bit 0 sits at the LSB.
  - counter += 1.
- After the edge processing counter=WIDTH-1 (edge k+WIDTH):
  - state=DONE, busy=0, done=1.
  - diff and borrow are updated from the result register and final br.
- DONE, next edge:
  - done returns to 0.
  - start=1 → behave as IDLE+start: relaunch, busy=1. This gives back-to-back throughput of one result per WIDTH+1 cycles.
  - start=0 → IDLE.
- start while BUSY is ignored; operands and progress are unaffected.
- Latency: start edge k → done high after edge k+WIDTH.
- diff/borrow hold their last value except at the BUSY→DONE update. They are not disturbed during a following operation.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around, e.g. 0-1, yields all-ones with borrow=1.
- Counter width is $clog2(WIDTH)+1 so it never overflows. The counter must never exceed WIDTH-1 in BUSY.

Decomposition:
- Package sub_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t.
  - Localparam DEFAULT_WIDTH = 4.
- Sub-module full_subtractor: purely combinational 1-bit cell (a, b, bin → d, bout), instantiated once by serial_subtractor.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Nominal: a=0x9, b=0x3, bin=0, start pulse → done exactly 4 cycles after the start edge; diff=0x6, borrow=0; busy high for exactly 4 cycles.
- Wrap and borrow: a=0x3, b=0x9, bin=0 → diff=0xA, borrow=1. Also a=0x0, b=0x0, bin=1 → diff=0xF, borrow=1. Also a=0xF, b=0xF, bin=0 → diff=0x0, borrow=0.
- Start while busy: start a=0x8, b=0x1, then pulse start with a=0x0, b=0xF two cycles later → the second request is ignored; diff=0x7, borrow=0; only one done pulse.
- Back-to-back: hold start=1 continuously with operands changing at each accept (5-2, then 2-5) → done pulses 5 cycles apart; results 0x3/0 then 0xD/1.
- Reset mid-operation: assert rst for one cycle at BUSY counter=2 → on the next edge busy=0, done=0, diff=0, borrow=0; no done follows. A new start then completes normally.
- Randomized: 200 random (a, b, bin) via $random → every diff/borrow matches the reference model {borrow, diff} = a - b - bin; WIDTH=8 regression also passes.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Operation bus of the serial subtractor.
// Handshake: start is taken only in IDLE/DONE, and operands are sampled on that same edge; busy
// is high while bits are processed, done pulses for one cycle when diff/borrow update.
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first, through one shared
// full-subtractor cell. The FSM state is exported on the state port for observation.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus,
    output sub_state_t          state
);
    localparam int              CW     = $clog2(WIDTH) + 1;
    localparam logic [1:0]      S_IDLE = IDLE;
    localparam logic [1:0]      S_BUSY = BUSY;
    localparam logic [1:0]      S_DONE = DONE;
    localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);

    logic [1:0]       st;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (st == S_BUSY) begin
            // Operands shift right so the cell always sees the current bit at position 0.
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {cell_d, res_sr[WIDTH-1:1]};
            br     <= cell_bout;
            if (cnt == LAST) begin
                st       <= S_DONE;
                diff_q   <= {cell_d, res_sr[WIDTH-1:1]};
                borrow_q <= cell_bout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (bus.start) begin
            // IDLE and DONE both accept a new operation, which gives back-to-back issue.
            a_sr <= bus.a;
            b_sr <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
            st   <= S_BUSY;
        end else begin
            st <= S_IDLE;
        end
    end

    assign bus.busy   = (st == S_BUSY);
    assign bus.done   = (st == S_DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign state      = sub_state_t'(st);
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8 against a plain-arithmetic model.
module tb_serial_subtractor;
    import sub_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];
    sub_state_t st4;
    sub_state_t st8;

    serial_subtractor_if #(.WIDTH(4)) b4 ();
    serial_subtractor_if #(.WIDTH(8)) b8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4), .state(st4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8), .state(st8));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, diff} is the (WIDTH+1)-bit unsigned result of a - b - bin.
    function automatic logic [4:0] ref4(input logic [3:0] a, b, input logic bin);
        return {1'b0, a} - {1'b0, b} - 5'(bin);
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, b, input logic bin);
        return {1'b0, a} - {1'b0, b} - 9'(bin);
    endfunction

    task automatic op4(input logic [3:0] a, b, input logic bin);
        int lat;
        int busy_cnt;
        logic [8:0] e;
        @(negedge clk);
        b4.start = 1'b1; b4.a = a; b4.b = b; b4.bin = bin;
        exp_q.push_back(9'(ref4(a, b, bin)));
        @(posedge clk); #1;
        b4.start = 1'b0; b4.a = 4'($urandom); b4.b = 4'($urandom); b4.bin = 1'($urandom);
        lat = 0;
        busy_cnt = b4.busy ? 1 : 0;
        while (!b4.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (b4.busy) busy_cnt++;
        end
        check("lat4", lat, 4);
        check("busy4", busy_cnt, 4);
        e = exp_q.pop_front();
        check("diff4", 32'(b4.diff), 32'(e[3:0]));
        check("borrow4", 32'(b4.borrow), 32'(e[4]));
    endtask

    task automatic op8(input logic [7:0] a, b, input logic bin);
        int lat;
        logic [8:0] e;
        @(negedge clk);
        b8.start = 1'b1; b8.a = a; b8.b = b; b8.bin = bin;
        exp_q.push_back(ref8(a, b, bin));
        @(posedge clk); #1;
        b8.start = 1'b0; b8.a = 8'($urandom); b8.b = 8'($urandom);
        lat = 0;
        while (!b8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat8", lat, 8);
        e = exp_q.pop_front();
        check("diff8", 32'(b8.diff), 32'(e[7:0]));
        check("borrow8", 32'(b8.borrow), 32'(e[8]));
    endtask

    initial begin
        int done_cnt;
        int done_e;
        int done_e2;
        logic [3:0] d1;
        logic [3:0] d2;
        logic br1;
        logic br2;

        b4.start = 1'b0; b4.a = '0; b4.b = '0; b4.bin = 1'b0;
        b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(b4.busy), 0);
        check("rst_done", 32'(b4.done), 0);
        check("rst_diff", 32'(b4.diff), 0);
        check("rst_borrow", 32'(b4.borrow), 0);
        check("rst_state", 32'(st4), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, including wrap-around.
        op4(4'h9, 4'h3, 1'b0);
        op4(4'h3, 4'h9, 1'b0);
        op4(4'h0, 4'h0, 1'b1);
        op4(4'hF, 4'hF, 1'b0);

        // A second start while busy must be ignored.
        @(negedge clk);
        b4.start = 1'b1; b4.a = 4'h8; b4.b = 4'h1; b4.bin = 1'b0;
        @(posedge clk); #1;
        b4.start = 1'b0;
        done_cnt = 0; done_e = -1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 2) begin
                @(negedge clk);
                b4.start = 1'b1; b4.a = 4'h0; b4.b = 4'hF;
            end
            @(posedge clk); #1;
            if (e == 2) b4.start = 1'b0;
            if (b4.done) begin
                done_cnt++;
                done_e = e;
                d1 = b4.diff;
                br1 = b4.borrow;
            end
        end
        check("ign_done_cnt", done_cnt, 1);
        check("ign_done_at", done_e, 4);
        check("ign_diff", 32'(d1), 32'h7);
        check("ign_borrow", 32'(br1), 0);

        // Back-to-back with start held high.
        @(negedge clk);
        b4.start = 1'b1; b4.a = 4'h5; b4.b = 4'h2; b4.bin = 1'b0;
        @(posedge clk); #1;
        b4.a = 4'h2; b4.b = 4'h5;
        done_cnt = 0; done_e = -1; done_e2 = -1;
        d1 = '0; d2 = '0; br1 = 1'b0; br2 = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (e == 5) b4.start = 1'b0;
            if (b4.done) begin
                done_cnt++;
                if (done_cnt == 1) begin done_e = e; d1 = b4.diff; br1 = b4.borrow; end
                else begin done_e2 = e; d2 = b4.diff; br2 = b4.borrow; end
            end
        end
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_first_at", done_e, 4);
        check("b2b_spacing", done_e2 - done_e, 5);
        check("b2b_diff1", 32'(d1), 32'h3);
        check("b2b_borrow1", 32'(br1), 0);
        check("b2b_diff2", 32'(d2), 32'hD);
        check("b2b_borrow2", 32'(br2), 1);

        // Reset at counter=2 aborts the operation.
        @(negedge clk);
        b4.start = 1'b1; b4.a = 4'h9; b4.b = 4'h3; b4.bin = 1'b0;
        @(posedge clk); #1;
        b4.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(b4.busy), 0);
        check("abort_done", 32'(b4.done), 0);
        check("abort_diff", 32'(b4.diff), 0);
        check("abort_borrow", 32'(b4.borrow), 0);
        done_cnt = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (b4.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        op4(4'h9, 4'h3, 1'b0);

        // Randomized regression at both widths.
        for (int i = 0; i < 200; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom_range(1, 0)));
        op8(8'h00, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 100; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));

        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
